// File: rtl/div_iter_param.sv
// Multi-cycle radix-2 non-restoring signed/unsigned integer divider (DIV/DIVU).
// Optional macro DIV_ZERO_FAST_EN: a zero divisor skips the iteration phase.
module div_iter_param #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_zero
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH:0]   r_q, r_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             sgn_a_q, sgn_a_d;
  logic             sgn_b_q, sgn_b_d;
  logic             zero_q, zero_d;
  logic [WIDTH-1:0] quotient_q, quotient_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;
  logic             div_zero_q, div_zero_d;
  logic             done_q, done_d;

  logic             neg_a, neg_b, divisor_zero, fast_zero;
  logic [WIDTH:0]   r_sh, r_step;
  logic [WIDTH-1:0] q_fix, r_fix;

  assign neg_a        = is_signed & dividend[WIDTH-1];
  assign neg_b        = is_signed & divisor[WIDTH-1];
  assign divisor_zero = (divisor == '0);
`ifdef DIV_ZERO_FAST_EN
  assign fast_zero    = divisor_zero;
`else
  assign fast_zero    = 1'b0;
`endif

  // State register.
  // NOTE: sequential state is assigned with <= so every flop samples pre-edge values.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic; abort only matters once an operation is in flight.
  // NOTE: default-assign every comb output first so no path leaves a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (start) state_d = fast_zero ? FIX : CALC;
      CALC: if (abort) state_d = IDLE;
            else if (cnt_q == LAST) state_d = FIX;
      FIX:  if (abort || cnt_q != '0) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output logic.
  always_comb begin
    busy = (state_q != IDLE);
  end

  // One non-restoring step: shift {R,Q}, subtract B if R>=0 else add B.
  assign r_sh   = {r_q[WIDTH-1:0], q_q[WIDTH-1]};
  assign r_step = r_q[WIDTH] ? (r_sh + {1'b0, b_q}) : (r_sh - {1'b0, b_q});
  // Truncating semantics: remainder takes the dividend's sign.
  assign q_fix  = (sgn_a_q ^ sgn_b_q) ? -q_q : q_q;
  assign r_fix  = sgn_a_q ? -r_q[WIDTH-1:0] : r_q[WIDTH-1:0];

  // FIX uses the counter as a sub-phase: 0 = remainder correction, 1 = publish.
  always_comb begin
    cnt_d       = cnt_q;
    r_d         = r_q;
    q_d         = q_q;
    b_d         = b_q;
    sgn_a_d     = sgn_a_q;
    sgn_b_d     = sgn_b_q;
    zero_d      = zero_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    div_zero_d  = div_zero_q;
    done_d      = 1'b0;
    unique case (state_q)
      IDLE: if (start) begin
        sgn_a_d = neg_a;
        sgn_b_d = neg_b;
        zero_d  = divisor_zero;
        q_d     = neg_a ? -dividend : dividend;
        b_d     = neg_b ? -divisor : divisor;
        r_d     = '0;
        cnt_d   = '0;
        // Fast zero path keeps the raw dividend to return as the remainder.
        if (fast_zero) q_d = dividend;
      end
      CALC: begin
        r_d   = r_step;
        q_d   = {q_q[WIDTH-2:0], ~r_step[WIDTH]};
        cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CNT_W'(1);
      end
      FIX: begin
        if (cnt_q == '0) begin
          if (r_q[WIDTH]) r_d = r_q + {1'b0, b_q};
          cnt_d = CNT_W'(1);
        end else begin
          quotient_d  = q_fix;
          remainder_d = r_fix;
          div_zero_d  = zero_q;
          done_d      = 1'b1;
`ifdef DIV_ZERO_FAST_EN
          if (zero_q) begin
            quotient_d  = '1;
            remainder_d = q_q;
          end
`endif
        end
      end
      default: ;
    endcase
    if (abort && state_q != IDLE) begin
      quotient_d  = quotient_q;
      remainder_d = remainder_q;
      div_zero_d  = div_zero_q;
      done_d      = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q       <= '0;
      r_q         <= '0;
      q_q         <= '0;
      b_q         <= '0;
      sgn_a_q     <= 1'b0;
      sgn_b_q     <= 1'b0;
      zero_q      <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      div_zero_q  <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      r_q         <= r_d;
      q_q         <= q_d;
      b_q         <= b_d;
      sgn_a_q     <= sgn_a_d;
      sgn_b_q     <= sgn_b_d;
      zero_q      <= zero_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      div_zero_q  <= div_zero_d;
      done_q      <= done_d;
    end
  end

  assign done      = done_q;
  assign quotient  = quotient_q;
  assign remainder = remainder_q;
  assign div_zero  = div_zero_q;

endmodule

// File: tb/tb_div_iter_param.sv
// Scoreboard bench for div_iter_param (WIDTH=32): directed vectors, monitor checks
// results and done-edge timing. Honours DIV_ZERO_FAST_EN if defined for the build.
module tb_div_iter_param;

  localparam int W   = 32;
  localparam int LAT = W + 2;
`ifdef DIV_ZERO_FAST_EN
  localparam int ZLAT = 2;
  localparam bit ZCHK = 1'b1;
`else
  localparam int ZLAT = LAT;
  localparam bit ZCHK = 1'b0;
`endif

  logic         clock = 1'b0;
  logic         reset_n = 1'b0;
  logic         start = 1'b0;
  logic         is_signed = 1'b0;
  logic [W-1:0] dividend = '0;
  logic [W-1:0] divisor = '0;
  logic         abort = 1'b0;
  logic         busy, done, div_zero;
  logic [W-1:0] quotient, remainder;

  div_iter_param #(.WIDTH(W)) dut (
    .clock(clock), .reset_n(reset_n), .start(start), .is_signed(is_signed),
    .dividend(dividend), .divisor(divisor), .abort(abort), .busy(busy),
    .done(done), .quotient(quotient), .remainder(remainder), .div_zero(div_zero)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dz;
    bit           chk;
    int           edge_n;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (edge %0d)", name, act, exp, cyc);
    end
  endtask

  // Drive one request at the next edge k = cyc+1; optionally expect a done at k+lat.
  task automatic issue(input bit sgn, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] eq, input logic [W-1:0] er, input logic edz,
                       input bit chk, input int lat, input bit push, input bit with_abort);
    exp_t e;
    @(negedge clock);
    start = 1'b1; is_signed = sgn; dividend = a; divisor = b; abort = with_abort;
    if (push) begin
      e.q = eq; e.r = er; e.dz = edz; e.chk = chk; e.edge_n = cyc + 1 + lat;
      sb.push_back(e);
    end
    @(posedge clock); #1;
    start = 1'b0; abort = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 100 && busy; i++) begin
      @(posedge clock); #1;
    end
    if (busy) check("busy_timeout", {31'b0, busy}, 32'd0);
  endtask

  task automatic run_op(input bit sgn, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] eq, input logic [W-1:0] er);
    issue(sgn, a, b, eq, er, 1'b0, 1'b1, LAT, 1'b1, 1'b0);
    wait_idle();
  endtask

  // Monitor: every done is matched against the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clock);
      cyc++;
      #1;
      if (done === 1'b1) begin
        if (sb.size() == 0) begin
          check("spurious_done", {31'b0, done}, 32'd0);
        end else begin
          e = sb.pop_front();
          check("done_edge", cyc, e.edge_n);
          check("div_zero", {31'b0, div_zero}, {31'b0, e.dz});
          if (e.chk) begin
            check("quotient", quotient, e.q);
            check("remainder", remainder, e.r);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (edge %0d)", cyc);
    $fatal(1);
  end

  initial begin
    #1;
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_done", {31'b0, done}, 32'd0);
    check("rst_quotient", quotient, 32'd0);
    check("rst_remainder", remainder, 32'd0);
    check("rst_div_zero", {31'b0, div_zero}, 32'd0);
    repeat (2) @(negedge clock);
    reset_n = 1'b1;

    // 100/7 with busy and output-hold checks along the way.
    issue(1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 1'b1, LAT, 1'b1, 1'b0);
    check("busy_at_k", {31'b0, busy}, 32'd1);
    repeat (20) @(posedge clock); #1;
    check("quotient_held_calc", quotient, 32'd0);
    repeat (13) @(posedge clock); #1;
    check("busy_at_k33", {31'b0, busy}, 32'd1);
    @(posedge clock); #1;
    check("busy_at_k34", {31'b0, busy}, 32'd0);
    check("done_at_k34", {31'b0, done}, 32'd1);
    @(posedge clock); #1;
    check("done_at_k35", {31'b0, done}, 32'd0);

    run_op(1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF);
    run_op(1'b0, 32'hFFFF_FFFF, 32'h10, 32'h0FFF_FFFF, 32'hF);
    run_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0);
    run_op(1'b1, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1);
    run_op(1'b1, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF);
    run_op(1'b0, 32'h8000_0000, 32'd3, 32'h2AAA_AAAA, 32'd2);
    run_op(1'b0, 32'd5, 32'd9, 32'd0, 32'd5);
    run_op(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, 32'd0);

    // Divide by zero, then a normal op must clear div_zero.
    issue(1'b0, 32'h1234, 32'd0, 32'hFFFF_FFFF, 32'h1234, 1'b1, ZCHK, ZLAT, 1'b1, 1'b0);
    wait_idle();
    check("div_zero_held", {31'b0, div_zero}, 32'd1);
    run_op(1'b0, 32'd100, 32'd7, 32'd14, 32'd2);

    // 50/5 with a second start and changed inputs at k+5, then back-to-back start.
    issue(1'b0, 32'd50, 32'd5, 32'd10, 32'd0, 1'b0, 1'b1, LAT, 1'b1, 1'b0);
    repeat (4) @(posedge clock);
    @(negedge clock);
    start = 1'b1; is_signed = 1'b1; dividend = 32'd999; divisor = 32'd3;
    @(posedge clock); #1;
    start = 1'b0;
    check("busy_after_ignored_start", {31'b0, busy}, 32'd1);
    repeat (29) @(posedge clock); #1;
    check("done_50_5", {31'b0, done}, 32'd1);
    issue(1'b0, 32'd81, 32'd9, 32'd9, 32'd0, 1'b0, 1'b1, LAT, 1'b1, 1'b0);
    check("b2b_busy", {31'b0, busy}, 32'd1);
    wait_idle();

    // Abort mid-operation: no done, results keep 81/9.
    issue(1'b0, 32'd200, 32'd3, '0, '0, 1'b0, 1'b0, LAT, 1'b0, 1'b0);
    repeat (10) @(posedge clock); #1;
    abort = 1'b1;
    @(posedge clock); #1;
    abort = 1'b0;
    check("abort_busy", {31'b0, busy}, 32'd0);
    check("abort_q_kept", quotient, 32'd9);
    check("abort_r_kept", remainder, 32'd0);
    repeat (40) @(posedge clock); #1;
    check("abort_q_still", quotient, 32'd9);

    // Abort in IDLE is a no-op; abort together with start: start wins.
    @(negedge clock); abort = 1'b1;
    @(posedge clock); #1; abort = 1'b0;
    check("idle_abort_busy", {31'b0, busy}, 32'd0);
    issue(1'b0, 32'd1000, 32'd10, 32'd100, 32'd0, 1'b0, 1'b1, LAT, 1'b1, 1'b1);
    check("start_beats_abort", {31'b0, busy}, 32'd1);
    wait_idle();

    // Asynchronous reset mid-operation.
    issue(1'b0, 32'd1000, 32'd7, '0, '0, 1'b0, 1'b0, LAT, 1'b0, 1'b0);
    repeat (5) @(posedge clock); #1;
    reset_n = 1'b0;
    #1;
    check("mid_rst_busy", {31'b0, busy}, 32'd0);
    check("mid_rst_done", {31'b0, done}, 32'd0);
    check("mid_rst_quotient", quotient, 32'd0);
    check("mid_rst_remainder", remainder, 32'd0);
    check("mid_rst_div_zero", {31'b0, div_zero}, 32'd0);
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    repeat (40) @(posedge clock); #1;
    check("post_rst_busy", {31'b0, busy}, 32'd0);
    run_op(1'b0, 32'd100, 32'd7, 32'd14, 32'd2);

    for (int i = 0; i < 100 && sb.size() != 0; i++) @(posedge clock);
    #2;
    check("scoreboard_drained", sb.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
